// File: rtl/reg_file_if.sv
// Register file access bundle: single write port plus NumReadPorts combinational read ports.
interface reg_file_if #(
   parameter int unsigned BitWidth     = 64,
   parameter int unsigned NumReg       = 32,
   parameter int unsigned NumReadPorts = 2
);
   localparam int unsigned RegSelWidth = $clog2(NumReg);

   logic                   write_en;
   logic [RegSelWidth-1:0] write_dest;
   logic [BitWidth-1:0]    write_data;
   logic [RegSelWidth-1:0] read_src  [NumReadPorts-1:0];
   logic [BitWidth-1:0]    read_data [NumReadPorts-1:0];

   modport master (
      output write_en, write_dest, write_data, read_src,
      input  read_data
   );

   modport slave (
      input  write_en, write_dest, write_data, read_src,
      output read_data
   );
endinterface

// File: rtl/reg_file.sv
// Integer register file: x0 hardwired to zero, one clocked write port, combinational reads.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file #(
   parameter int unsigned BitWidth     = 64,
   parameter int unsigned NumReg       = 32,
   parameter int unsigned NumReadPorts = 2
) (
   input logic     clk,
   input logic     rst,
   reg_file_if.slave rf
);
   localparam int unsigned RegSelWidth = $clog2(NumReg);

   logic [BitWidth-1:0] regs [NumReg-1:1];

   // Only indices 1..NumReg-1 have storage, so writes to x0 or past the top are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 1; r < NumReg; r++) begin
            regs[r] <= '0;
         end
      end else begin
         for (int unsigned r = 1; r < NumReg; r++) begin
            if (rf.write_en && (rf.write_dest == RegSelWidth'(r))) begin
               regs[r] <= rf.write_data;
            end
         end
      end
   end

   // Unmatched indices (x0, out of range) fall through to zero.
   always_comb begin
      for (int unsigned p = 0; p < NumReadPorts; p++) begin
         rf.read_data[p] = '0;
         for (int unsigned r = 1; r < NumReg; r++) begin
            if (rf.read_src[p] == RegSelWidth'(r)) begin
`ifdef REGFILE_BYPASS_EN
               if (!rst && rf.write_en && (rf.write_dest == RegSelWidth'(r))) begin
                  rf.read_data[p] = rf.write_data;
               end else begin
                  rf.read_data[p] = regs[r];
               end
`else
               rf.read_data[p] = regs[r];
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (default 64-bit, 32 registers, 2 read ports).
module tb_reg_file;
   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic [63:0] model [32];

   reg_file_if #(.BitWidth(64), .NumReg(32), .NumReadPorts(2)) rf ();

   reg_file #(.BitWidth(64), .NumReg(32), .NumReadPorts(2)) dut (
      .clk (clk),
      .rst (rst),
      .rf  (rf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic do_write(input logic [4:0] d, input logic [63:0] v);
      @(negedge clk);
      rf.write_en   = 1'b1;
      rf.write_dest = d;
      rf.write_data = v;
      @(posedge clk);
      #1;
      rf.write_en   = 1'b0;
   endtask

   task automatic set_src(input logic [4:0] s0, input logic [4:0] s1);
      rf.read_src[0] = s0;
      rf.read_src[1] = s1;
      #1;
   endtask

   task automatic test_reset;
      set_src(5'd5, 5'd31);
      for (int p = 0; p < 2; p++) begin
         total++;
         if (rf.read_data[p] !== 64'h0) begin
            bad++;
            $display("FAIL reset_init_p%0d got=%h exp=%h", p, rf.read_data[p], 64'h0);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      do_write(5'd5, 64'hDEAD_BEEF_0000_0001);
      set_src(5'd5, 5'd5);
      total++;
      if (rf.read_data[0] !== 64'hDEAD_BEEF_0000_0001) begin
         bad++;
         $display("FAIL reset_prewrite got=%h exp=%h", rf.read_data[0], 64'hDEAD_BEEF_0000_0001);
      end
      // assert reset mid-cycle with a write pending; clear must be immediate
      @(negedge clk);
      #2;
      rst           = 1'b1;
      rf.write_en   = 1'b1;
      rf.write_dest = 5'd5;
      rf.write_data = 64'h1234;
      #1;
      for (int p = 0; p < 2; p++) begin
         total++;
         if (rf.read_data[p] !== 64'h0) begin
            bad++;
            $display("FAIL reset_async_p%0d got=%h exp=%h", p, rf.read_data[p], 64'h0);
         end
      end
      @(posedge clk);
      #1;
      total++;
      if (rf.read_data[0] !== 64'h0) begin
         bad++;
         $display("FAIL reset_write_ignored got=%h exp=%h", rf.read_data[0], 64'h0);
      end
      @(negedge clk);
      rst         = 1'b0;
      rf.write_en = 1'b0;
      #1;
      total++;
      if (rf.read_data[1] !== 64'h0) begin
         bad++;
         $display("FAIL reset_after got=%h exp=%h", rf.read_data[1], 64'h0);
      end
   endtask

   task automatic test_fill;
      model[0] = 64'h0;
      for (int i = 1; i < 32; i++) begin
         model[i] = {$urandom, $urandom};
      end
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         rf.write_en   = 1'b1;
         rf.write_dest = 5'(i);
         rf.write_data = model[i];
      end
      @(negedge clk);
      rf.write_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         set_src(5'(i), 5'(31 - i));
         total++;
         if (rf.read_data[0] !== model[i]) begin
            bad++;
            $display("FAIL fill_p0_x%0d got=%h exp=%h", i, rf.read_data[0], model[i]);
         end
         total++;
         if (rf.read_data[1] !== model[31 - i]) begin
            bad++;
            $display("FAIL fill_p1_x%0d got=%h exp=%h", 31 - i, rf.read_data[1], model[31 - i]);
         end
      end
   endtask

   task automatic test_x0;
      do_write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      set_src(5'd0, 5'd0);
      for (int p = 0; p < 2; p++) begin
         total++;
         if (rf.read_data[p] !== 64'h0) begin
            bad++;
            $display("FAIL x0_p%0d got=%h exp=%h", p, rf.read_data[p], 64'h0);
         end
      end
   endtask

   task automatic test_write_enable;
      do_write(5'd7, 64'h1234);
      @(negedge clk);
      rf.write_en   = 1'b0;
      rf.write_dest = 5'd7;
      rf.write_data = 64'h5678;
      repeat (3) @(posedge clk);
      #1;
      set_src(5'd7, 5'd7);
      for (int p = 0; p < 2; p++) begin
         total++;
         if (rf.read_data[p] !== 64'h1234) begin
            bad++;
            $display("FAIL wen_gate_p%0d got=%h exp=%h", p, rf.read_data[p], 64'h1234);
         end
      end
   endtask

   task automatic test_same_cycle;
      logic [63:0] exp_now;
`ifdef REGFILE_BYPASS_EN
      exp_now = 64'hB;
`else
      exp_now = 64'hA;
`endif
      do_write(5'd9, 64'hA);
      @(negedge clk);
      rf.write_en   = 1'b1;
      rf.write_dest = 5'd9;
      rf.write_data = 64'hB;
      set_src(5'd9, 5'd9);
      total++;
      if (rf.read_data[0] !== exp_now) begin
         bad++;
         $display("FAIL rw_same_cycle got=%h exp=%h", rf.read_data[0], exp_now);
      end
      @(posedge clk);
      #1;
      rf.write_en = 1'b0;
      #1;
      total++;
      if (rf.read_data[1] !== 64'hB) begin
         bad++;
         $display("FAIL rw_after_edge got=%h exp=%h", rf.read_data[1], 64'hB);
      end
   endtask

   task automatic test_port_independence;
      do_write(5'd3, 64'h3333_0000_0000_0003);
      do_write(5'd4, 64'h4444_0000_0000_0004);
      set_src(5'd3, 5'd3);
      total++;
      if (rf.read_data[0] !== 64'h3333_0000_0000_0003) begin
         bad++;
         $display("FAIL ports_same_p0 got=%h exp=%h", rf.read_data[0], 64'h3333_0000_0000_0003);
      end
      total++;
      if (rf.read_data[1] !== 64'h3333_0000_0000_0003) begin
         bad++;
         $display("FAIL ports_same_p1 got=%h exp=%h", rf.read_data[1], 64'h3333_0000_0000_0003);
      end
      set_src(5'd3, 5'd4);
      total++;
      if (rf.read_data[0] !== 64'h3333_0000_0000_0003) begin
         bad++;
         $display("FAIL ports_diff_p0 got=%h exp=%h", rf.read_data[0], 64'h3333_0000_0000_0003);
      end
      total++;
      if (rf.read_data[1] !== 64'h4444_0000_0000_0004) begin
         bad++;
         $display("FAIL ports_diff_p1 got=%h exp=%h", rf.read_data[1], 64'h4444_0000_0000_0004);
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      rf.write_en   = 1'b1;
      rf.write_dest = 5'd12;
      rf.write_data = 64'h1111;
      @(negedge clk);
      rf.write_data = 64'h2222;
      @(negedge clk);
      rf.write_en = 1'b0;
      set_src(5'd12, 5'd3);
      total++;
      if (rf.read_data[0] !== 64'h2222) begin
         bad++;
         $display("FAIL back_to_back got=%h exp=%h", rf.read_data[0], 64'h2222);
      end
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      rst            = 1'b1;
      rf.write_en    = 1'b0;
      rf.write_dest  = '0;
      rf.write_data  = '0;
      rf.read_src[0] = '0;
      rf.read_src[1] = '0;
      repeat (2) @(posedge clk);
      test_reset;
      test_fill;
      test_x0;
      test_write_enable;
      test_same_cycle;
      test_port_independence;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/reg_file.md
# reg_file

Parameterised multi-read-port, single-write-port integer register file for the RV32I/RV64I core datapath. Holds `NumReg` architectural registers of `BitWidth` bits. Register x0 is hardwired to zero. Reads are combinational for operand fetch in decode; the single write port is clocked and driven by writeback.

## Interface
- `BitWidth`, default 64: register width in bits.
- `NumReg`, default 32: number of registers; any value ≥ 2.
- `NumReadPorts`, default 2: number of independent read ports; ≥ 1.
- `RegSelWidth`, derived as `$clog2(NumReg)`, not overridable: width of every register index.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `write_en`  in  1  write enable for the current cycle.
- `write_dest`  in  RegSelWidth  destination register index.
- `write_data`  in  BitWidth  data to write.
- `read_src`  in  unpacked array [NumReadPorts-1:0] of RegSelWidth  source index per read port.
- `read_data`  out  unpacked array [NumReadPorts-1:0] of BitWidth  read data per port.

## Operation
- Storage: registers 1 to NumReg-1 are flops. Register 0 has no storage.
- Write: on a rising `clk` with `write_en`=1 and `rst`=0, `write_dest` is loaded with `write_data`.
- Writes to index 0 are discarded.
- Writes to index ≥ NumReg are discarded. This only applies when NumReg is not a power of two.
- Read: each port is independent and combinational.
  - `read_data[p]` = contents of `read_src[p]`.
  - Index 0 reads all zeros.
  - Index ≥ NumReg reads all zeros.
- Several ports may select the same register. Each returns the same value.
- The read ports have no enables and no side effects.

## Timing
- Reset: asserting `rst` clears every register to 0 immediately, without waiting for a clock edge.
  - All `read_data` outputs read 0 while `rst` is high.
  - Writes are ignored while `rst` is high, including a write on the edge where `rst` is asserted.
- Reset mid-operation: any write presented in the same cycle as `rst` assertion is lost.
- Write latency: one edge. The new value is visible on reads after the rising edge that commits it. Before that edge, reads return the old value, unless bypass is enabled (see Configuration).
- Read latency: zero cycles, purely combinational from `read_src` and register state.
- Simultaneous read and write of the same index:
  - Without bypass: the read returns the old value during that cycle and the new value after the edge.
- Back-to-back writes to the same register: the last committed write wins.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: write-to-read forwarding is compiled in.
  - Condition: `write_en`=1, `rst`=0, `write_dest`=`read_src[p]`, and `write_dest`≠0 and < NumReg.
  - When the condition holds, `read_data[p]` = `write_data` combinationally in the same cycle.
  - Index 0 is never bypassed.
- Undefined: no forwarding. Reads always reflect committed register state only.
- Storage behaviour and write timing are identical in both builds.

## Test plan
- Reset clear: write x5 = 64'hDEAD_BEEF_0000_0001, then pulse `rst` between clock edges. All read ports must return 0 immediately, and x5 must read 0 afterwards.
- Fill and readback: after reset, write a random value to x1..x31 one per cycle. Read every index on each of the 2 ports; each must match its written value, and x0 must read 0.
- x0 immutability: write x0 = 64'hFFFF_FFFF_FFFF_FFFF with `write_en`=1, then read x0 on all ports. The result must be 0.
- Write enable gating: set x7 = 64'h1234, then present x7 = 64'h5678 with `write_en`=0 for 3 edges. x7 must still read 64'h1234.
- Same-cycle read/write of x9: old value 64'hA, new value 64'hB. Read x9 in the write cycle and after the edge.
  - Write cycle: 64'hA without `REGFILE_BYPASS_EN`, 64'hB with it.
  - After the edge: 64'hB in both builds.
- Port independence: `read_src` = {x3, x3} and then {x3, x4} with distinct contents. Each port must return its own register's value with no cross-port interference.
